// File: rtl/stream_grant_mux.sv
// stream_grant_mux
//   Funnels NUM_REQ valid/ready payload streams into one output stream.
//   An external arbiter picks the requester. This block sends the request
//   vector out, checks the returned grant, handshakes the winner, and holds
//   its payload until downstream accepts it.
//
// Ports
//   clk_i, rst_n_i   clock, async active-low reset
//   in_valid_i       per-requester valid            [NUM_REQ]
//   in_data_i        packed payloads, k at [k*DW +: DW]
//   in_ready_o       per-requester ready (comb, at most one hot)
//   req_o, req_en_o  request vector / strobe to the arbiter (registered)
//   grant_i          arbiter grant, expected one-hot or zero
//   out_valid_o      held payload valid
//   out_data_o       held payload
//   out_src_o        held payload source index
//   out_ready_i      downstream ready
//   err_o            one-cycle pulse on an illegal grant
module stream_grant_mux #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GRANT_LAT  = 1,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            in_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_REQ-1:0]            in_ready_o,
  output logic [NUM_REQ-1:0]            req_o,
  output logic                          req_en_o,
  input  logic [NUM_REQ-1:0]            grant_i,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [SRC_W-1:0]              out_src_o,
  input  logic                          out_ready_i,
  output logic                          err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, OUTPUT} state_t;

  state_t                 state, state_n;
  logic                   sample;
  logic                   onehot;
  logic                   grant_ok;
  logic                   grant_bad;
  logic [SRC_W-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Grant decode. grant_ok requires a one-hot grant that points at a
  // requester that is actually valid; any other non-zero grant is an error.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_i[k]) begin
        sel_idx  = SRC_W'(k);
        sel_data = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    onehot    = (grant_i != '0) && ((grant_i & (grant_i - NUM_REQ'(1))) == '0);
    grant_ok  = onehot && ((grant_i & in_valid_i) != '0);
    grant_bad = (grant_i != '0) && !grant_ok;
  end

  // Cycle in which grant_i is meaningful. With zero latency the arbiter
  // answers in the very cycle the strobe is out.
  always_comb begin
    if (GRANT_LAT == 0) sample = (state == IDLE) && req_en_o;
    else                sample = (state == WAIT_GRANT);
  end

  assign in_ready_o = (sample && grant_ok) ? grant_i : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_en_o) begin
          if (GRANT_LAT == 0) state_n = grant_ok ? OUTPUT : IDLE;
          else                state_n = WAIT_GRANT;
        end
      end
      WAIT_GRANT: state_n = grant_ok ? OUTPUT : IDLE;
      OUTPUT:     state_n = out_ready_i ? IDLE : OUTPUT;
      default:    state_n = IDLE;
    endcase
  end

  // The request strobe is registered, so it is computed on the edge that
  // lands us in IDLE: one strobe per IDLE visit, and a zero or bad grant
  // re-enters IDLE and therefore re-requests immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      req_o       <= '0;
      req_en_o    <= 1'b0;
      err_o       <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
    end else begin
      state       <= state_n;
      req_en_o    <= (state_n == IDLE) && (in_valid_i != '0);
      req_o       <= (state_n == IDLE) ? in_valid_i : '0;
      err_o       <= sample && grant_bad;
      out_valid_o <= (state_n == OUTPUT);
      if (sample && grant_ok) begin
        out_data_o <= sel_data;
        out_src_o  <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_grant_mux.sv
// Bench for stream_grant_mux (NUM_REQ=4, DATA_WIDTH=8, GRANT_LAT=1).
// Directed stimulus drives the arbiter side; each expected transfer is
// pushed into a queue and a negedge monitor pops and compares it whenever
// the DUT completes an output handshake.
module tb_stream_grant_mux;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      in_valid;
  logic [3:0][7:0] din;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic            req_en;
  logic [3:0]      grant;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  stream_grant_mux #(.NUM_REQ(4), .DATA_WIDTH(8), .GRANT_LAT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(din),
    .in_ready_o(in_ready), .req_o(req), .req_en_o(req_en), .grant_i(grant),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src),
    .out_ready_i(out_ready), .err_o(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completed output handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got data %0h src %0d with nothing expected", out_data, out_src);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("xfer_data", {24'h0, out_data}, {24'h0, e[9:2]});
        chk("xfer_src", {30'h0, out_src}, {30'h0, e[1:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle with the strobe up; leaves in the next IDLE cycle.
  task automatic do_xfer(input logic [3:0] g, input logic [7:0] d, input logic [1:0] s);
    chk("xfer_req_en_idle", {31'h0, req_en}, 32'h1);
    tick();
    grant = g;
    #1;
    chk("xfer_in_ready", {28'h0, in_ready}, {28'h0, g});
    chk("xfer_req_en_wait", {31'h0, req_en}, 32'h0);
    exp_q.push_back({d, s});
    tick();
    grant = 4'b0000;
    #1;
    chk("xfer_out_valid", {31'h0, out_valid}, 32'h1);
    tick();
    chk("xfer_out_valid_clr", {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0; grant = 4'b0; out_ready = 1'b0;
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (3) tick();
    chk("rst_in_ready", {28'h0, in_ready}, 32'h0);
    chk("rst_req", {28'h0, req}, 32'h0);
    chk("rst_req_en", {31'h0, req_en}, 32'h0);
    chk("rst_out", {21'h0, out_valid, out_data, out_src}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Release with requests already pending: strobe only after the next edge.
    in_valid = 4'b1111; out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_req", {31'h0, req_en}, 32'h0);
    tick();
    chk("first_req_en", {31'h0, req_en}, 32'h1);
    chk("first_req", {28'h0, req}, 32'hF);

    // Round-robin sweep, one transfer every 3 cycles.
    do_xfer(4'b1000, 8'hA3, 2'd3);
    do_xfer(4'b0100, 8'hA2, 2'd2);
    do_xfer(4'b0010, 8'hA1, 2'd1);
    do_xfer(4'b0001, 8'hA0, 2'd0);

    // Back-pressure: payload held for 4 stalled cycles.
    din[3] = 8'h5C;
    tick();
    grant = 4'b1000;
    tick();
    grant = 4'b0000; out_ready = 1'b0;
    exp_q.push_back({8'h5C, 2'd3});
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_data", {24'h0, out_data}, 32'h5C);
      chk("stall_req_en", {31'h0, req_en}, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_valid", {31'h0, out_valid}, 32'h1);
    tick();
    chk("stall_done_valid", {31'h0, out_valid}, 32'h0);
    chk("stall_done_req_en", {31'h0, req_en}, 32'h1);

    // Non-one-hot grant.
    tick();
    grant = 4'b0110;
    #1;
    chk("bad_oh_in_ready", {28'h0, in_ready}, 32'h0);
    tick();
    grant = 4'b0000;
    #1;
    chk("bad_oh_err", {31'h0, err}, 32'h1);
    chk("bad_oh_no_valid", {31'h0, out_valid}, 32'h0);
    chk("bad_oh_re_req", {31'h0, req_en}, 32'h1);
    tick();
    chk("bad_oh_err_pulse", {31'h0, err}, 32'h0);
    // WAIT with zero grant: silent retry.
    tick();
    chk("zero_err", {31'h0, err}, 32'h0);
    chk("zero_re_req", {31'h0, req_en}, 32'h1);

    // Grant to a requester that is not valid.
    in_valid = 4'b0001;
    tick();
    grant = 4'b0100;
    #1;
    chk("inval_in_ready", {28'h0, in_ready}, 32'h0);
    tick();
    grant = 4'b0000;
    #1;
    chk("inval_err", {31'h0, err}, 32'h1);
    chk("inval_no_valid", {31'h0, out_valid}, 32'h0);
    chk("inval_req", {28'h0, req}, 32'h1);
    tick();
    chk("inval_err_pulse", {31'h0, err}, 32'h0);
    tick();
    chk("retry_err", {31'h0, err}, 32'h0);
    din[0] = 8'h3E;
    do_xfer(4'b0001, 8'h3E, 2'd0);

    // Reset while holding a payload: nothing must reach downstream.
    din[0] = 8'h77; in_valid = 4'b0011;
    tick();
    grant = 4'b0001;
    tick();
    grant = 4'b0000; out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {21'h0, out_valid, out_data, out_src}, 32'h0);
    chk("mid_rst_ctl", {22'h0, req_en, req, err, in_ready}, 32'h0);
    tick();
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_no_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("rel_req", {28'h0, req}, 32'h3);
    chk("rel_valid", {31'h0, out_valid}, 32'h0);
    din[1] = 8'h91;
    do_xfer(4'b0010, 8'h91, 2'd1);

    tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
